pc_fetch_unit: RTL and testbench

- Program-counter and fetch-sequencing stage for the RISC-V core.
- Sits downstream of the ALU. Consumes the ALU branch flag and result to select the next PC.
- Drives the instruction-memory request handshake, so the core tolerates variable-latency instruction memory.
- Detects misaligned control-flow targets and parks in a trap state.

---
 rtl/pc_fetch_unit.sv | 133 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: BOOT -> FETCH <-> EXEC, parking in TRAP on a misaligned target.
// Optional 64-bit retired-instruction counter (instret) enabled by defining RETIRE_CNT_EN.
module pc_fetch_unit #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   PCsrc,
    input  logic         ALUflag,
    input  logic [W-1:0] ALUout,
    input  logic [W-1:0] ImmExt,
    input  logic         stall,
    input  logic         imem_ready,
    output logic         imem_req,
    output logic [W-1:0] PC,
    output logic [W-1:0] PCPlus4,
    output logic [W-1:0] PCTarget,
    output logic         instr_valid,
    output logic         trap
`ifdef RETIRE_CNT_EN
    ,
    output logic [63:0]  instret
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } state_e;

    localparam logic [W-1:0] PC_STEP = {{(W-3){1'b0}}, 3'b100};

    state_e       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] pc_next_s;
    logic         misalign_s;
    logic         imem_req_q, instr_valid_q, trap_q;

    assign PCPlus4  = pc_q + PC_STEP;
    assign PCTarget = pc_q + ImmExt;
    assign PC       = pc_q;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;
    assign trap        = trap_q;

    // Candidate next PC; jalr clears bit 0 of the ALU result.
    always_comb begin
        pc_next_s = PCPlus4;
        case (PCsrc)
            2'b00:   pc_next_s = PCPlus4;
            2'b01:   pc_next_s = ALUflag ? PCTarget : PCPlus4;
            2'b10:   pc_next_s = PCTarget;
            2'b11:   pc_next_s = {ALUout[W-1:1], 1'b0};
            default: pc_next_s = PCPlus4;
        endcase
    end

    assign misalign_s = (pc_next_s[1:0] != 2'b00);

    // Next-state and next-PC logic; a misaligned target leaves PC on the faulting instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    state_d = EXEC;
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC: begin
                if (stall) begin
                    state_d = EXEC;
                end else if (misalign_s) begin
                    state_d = TRAP;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_next_s;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and state-decoded output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= (state_d == FETCH);
            instr_valid_q <= (state_d == EXEC);
            trap_q        <= (state_d == TRAP);
        end
    end

`ifdef RETIRE_CNT_EN
    logic        retire_s;
    logic [63:0] instret_q;

    assign retire_s = (state_q == EXEC) && !stall && !misalign_s;
    assign instret  = instret_q;

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (retire_s) begin
            instret_q <= instret_q + 64'd1;
        end else begin
            instret_q <= instret_q;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected PCs are queued when control inputs are driven
// and popped when the DUT presents the instruction in EXEC (instr_valid).
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic        ALUflag = 1'b0;
    logic [31:0] ALUout = 32'h0;
    logic [31:0] ImmExt = 32'h0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;

    logic        imem_req, instr_valid, trap;
    logic [31:0] PC, PCPlus4, PCTarget;
    logic        w_imem_req, w_instr_valid, w_trap;
    logic [31:0] w_pc, w_pcplus4, w_pctarget;
`ifdef RETIRE_CNT_EN
    logic [63:0] instret, w_instret;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    bit          ok;

    always #5 clk = ~clk;

    pc_fetch_unit #(.W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .ALUflag(ALUflag), .ALUout(ALUout),
        .ImmExt(ImmExt), .stall(stall), .imem_ready(imem_ready), .imem_req(imem_req),
        .PC(PC), .PCPlus4(PCPlus4), .PCTarget(PCTarget), .instr_valid(instr_valid),
        .trap(trap)
`ifdef RETIRE_CNT_EN
        , .instret(instret)
`endif
    );

    pc_fetch_unit #(.W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .PCsrc(PCsrc), .ALUflag(ALUflag), .ALUout(ALUout),
        .ImmExt(ImmExt), .stall(stall), .imem_ready(imem_ready), .imem_req(w_imem_req),
        .PC(w_pc), .PCPlus4(w_pcplus4), .PCTarget(w_pctarget), .instr_valid(w_instr_valid),
        .trap(w_trap)
`ifdef RETIRE_CNT_EN
        , .instret(w_instret)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; PCsrc = 2'b00; ALUflag = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        ALUout = 32'h0; ImmExt = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    // Bounded wait for the next instruction to reach EXEC.
    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        n_cmp++; if ({imem_req, instr_valid, trap} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b want 000", {imem_req, instr_valid, trap}); end
        n_cmp++; if (w_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc_w: got %h want fffffffc", w_pc); end
    endtask

    task automatic test_sequential();
        imem_ready = 1'b1; PCsrc = 2'b00;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("FAIL seq_fetch%0d: got %b want 10", i, {imem_req, instr_valid}); end
            tick();
            n_cmp++; if ({imem_req, instr_valid} !== 2'b01) begin n_fail++; $display("FAIL seq_exec%0d: got %b want 01", i, {imem_req, instr_valid}); end
            exp_pc = sb.pop_front();
            n_cmp++; if (PC !== exp_pc) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, PC, exp_pc); end
            n_cmp++; if (PCPlus4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL seq_pc4_%0d: got %h want %h", i, PCPlus4, exp_pc + 32'd4); end
        end
        sb.push_back(32'h10);
        tick(); wait_valid(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL seq_to10_timeout: got no instr_valid want 1"); end
        exp_pc = sb.pop_front();
        n_cmp++; if (PC !== exp_pc) begin n_fail++; $display("FAIL seq_to10: got %h want %h", PC, exp_pc); end
    endtask

    task automatic test_branch();
        PCsrc = 2'b01; ImmExt = 32'hFFFF_FFF8; ALUflag = 1'b1;
        #1;
        n_cmp++; if (PCTarget !== 32'h8) begin n_fail++; $display("FAIL br_target: got %h want %h", PCTarget, 32'h8); end
        sb.push_back(32'h8);
        tick(); wait_valid(ok);
        exp_pc = sb.pop_front();
        n_cmp++; if (!ok || PC !== exp_pc) begin n_fail++; $display("FAIL br_taken: got %h want %h", PC, exp_pc); end
        PCsrc = 2'b10; ImmExt = 32'h8; ALUflag = 1'b0;
        sb.push_back(32'h10);
        tick(); wait_valid(ok);
        exp_pc = sb.pop_front();
        n_cmp++; if (!ok || PC !== exp_pc) begin n_fail++; $display("FAIL jal_flag0: got %h want %h", PC, exp_pc); end
        PCsrc = 2'b01; ImmExt = 32'hFFFF_FFF8; ALUflag = 1'b0;
        sb.push_back(32'h14);
        tick(); wait_valid(ok);
        exp_pc = sb.pop_front();
        n_cmp++; if (!ok || PC !== exp_pc) begin n_fail++; $display("FAIL br_not_taken: got %h want %h", PC, exp_pc); end
    endtask

    task automatic test_trap();
        PCsrc = 2'b10; ImmExt = 32'hC;
        sb.push_back(32'h20);
        tick(); wait_valid(ok);
        exp_pc = sb.pop_front();
        n_cmp++; if (!ok || PC !== exp_pc) begin n_fail++; $display("FAIL trap_setup: got %h want %h", PC, exp_pc); end
        PCsrc = 2'b11; ALUout = 32'h0000_1003;
        tick();
        n_cmp++; if ({trap, imem_req, instr_valid} !== 3'b100) begin n_fail++; $display("FAIL trap_enter: got %b want 100", {trap, imem_req, instr_valid}); end
        n_cmp++; if (PC !== 32'h20) begin n_fail++; $display("FAIL trap_pc: got %h want %h", PC, 32'h20); end
        PCsrc = 2'b00; imem_ready = 1'b1; stall = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if ({trap, imem_req, instr_valid} !== 3'b100 || PC !== 32'h20) begin n_fail++; $display("FAIL trap_sticky: got %b/%h want 100/00000020", {trap, imem_req, instr_valid}, PC); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({trap, imem_req, instr_valid} !== 3'b000 || PC !== 32'h0) begin n_fail++; $display("FAIL trap_reset: got %b/%h want 000/00000000", {trap, imem_req, instr_valid}, PC); end
    endtask

    task automatic test_handshake_stall();
        do_reset();
        imem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({imem_req, instr_valid} !== 2'b10 || PC !== 32'h8) begin n_fail++; $display("FAIL hs_wait%0d: got %b/%h want 10/00000008", i, {imem_req, instr_valid}, PC); end
        end
        imem_ready = 1'b1;
        tick();
        n_cmp++; if (instr_valid !== 1'b1 || PC !== 32'h8) begin n_fail++; $display("FAIL hs_exec: got %b/%h want 1/00000008", instr_valid, PC); end
        stall = 1'b1; PCsrc = 2'b10; ImmExt = 32'h40;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if ({imem_req, instr_valid} !== 2'b01 || PC !== 32'h8) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%h want 01/00000008", i, {imem_req, instr_valid}, PC); end
        end
        stall = 1'b0;
        sb.push_back(32'h48);
        tick(); wait_valid(ok);
        exp_pc = sb.pop_front();
        n_cmp++; if (!ok || PC !== exp_pc) begin n_fail++; $display("FAIL stall_release: got %h want %h", PC, exp_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b1; PCsrc = 2'b00;
        tick(); tick();
        n_cmp++; if (w_pc !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h/%h want fffffffc/00000000", w_pc, w_pcplus4); end
        tick();
        n_cmp++; if (w_pc !== 32'h0 || w_trap !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got %h/%b want 00000000/0", w_pc, w_trap); end
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        imem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        imem_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (PC !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %h/%b want 00000008/1", PC, imem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (PC !== 32'h0 || {imem_req, instr_valid, trap} !== 3'b000) begin n_fail++; $display("FAIL mid_reset: got %h/%b want 00000000/000", PC, {imem_req, instr_valid, trap}); end
`ifdef RETIRE_CNT_EN
        n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL instret_reset: got %0d want 0", instret); end
`endif
        tick();
        n_cmp++; if (imem_req !== 1'b1 || PC !== 32'h0) begin n_fail++; $display("FAIL mid_boot_exit: got %b/%h want 1/00000000", imem_req, PC); end
        imem_ready = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        n_cmp++; if (PC !== 32'hC) begin n_fail++; $display("FAIL mid_retire_pc: got %h want %h", PC, 32'hC); end
`ifdef RETIRE_CNT_EN
        n_cmp++; if (instret !== 64'd3) begin n_fail++; $display("FAIL instret_count: got %0d want 3", instret); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_trap();
        test_handshake_stall();
        test_wrap();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule
